// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures a WIDTH-bit pattern on start and shifts it out
// MSB-first, optionally repeating it rpt extra times with GAP idle cycles between copies.
module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       rpt,
    output logic             dout,
    output logic             dvalid,
    output logic             busy,
    output logic             done
);

    localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e            state_q,  state_d;
    logic [WIDTH-1:0]  shreg_q,  shreg_d;
    logic [WIDTH-1:0]  saved_q,  saved_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic [3:0]        repcnt_q, repcnt_d;
    logic [3:0]        gapcnt_q, gapcnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            saved_q  <= '0;
            bitcnt_q <= '0;
            repcnt_q <= '0;
            gapcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            saved_q  <= saved_d;
            bitcnt_q <= bitcnt_d;
            repcnt_q <= repcnt_d;
            gapcnt_q <= gapcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        saved_d  = saved_q;
        bitcnt_d = bitcnt_q;
        repcnt_d = repcnt_q;
        gapcnt_d = gapcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d  = pattern;
                    saved_d  = pattern;
                    repcnt_d = rpt;
                    bitcnt_d = BIT_LAST;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q - 1'b1;
                if (bitcnt_q == '0) begin
                    if (repcnt_q == 4'd0) begin
                        state_d = ST_DONE;
                    end else if (GAP == 0) begin
                        // Back-to-back copies: reload without leaving SHIFT so dvalid stays high.
                        shreg_d  = saved_q;
                        bitcnt_d = BIT_LAST;
                        repcnt_d = repcnt_q - 4'd1;
                    end else begin
                        gapcnt_d = GAP_LOAD;
                        repcnt_d = repcnt_q - 4'd1;
                        state_d  = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                gapcnt_d = gapcnt_q - 4'd1;
                if (gapcnt_q == 4'd0) begin
                    shreg_d  = saved_q;
                    bitcnt_d = BIT_LAST;
                    state_d  = ST_SHIFT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs: decoded only from registered state and the shift register.
    always_comb begin
        dout   = (state_q == ST_SHIFT) && shreg_q[WIDTH-1];
        dvalid = (state_q == ST_SHIFT);
        busy   = (state_q == ST_SHIFT) || (state_q == ST_GAP);
        done   = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: three instances (4/0, 4/2, 16/15) checked cycle by cycle
// against an expected record stream built from the transfer rules.
module tb_seq_pattern_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_r = 3'b000;
    logic [15:0] pat_r [3];
    logic [3:0]  rpt_r [3];
    logic [2:0]  dout_w, dvalid_w, busy_w, done_w;

    int inst_w [3] = '{4, 4, 16};
    int inst_g [3] = '{0, 2, 15};

    int errors = 0;
    int checks = 0;
    int sel    = 0;

    // Records are {done, busy, dvalid, dout} for one clock cycle.
    logic [3:0] exp_q[$];
    logic [3:0] mon_act, mon_exp;

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(4), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .pattern(pat_r[0][3:0]), .rpt(rpt_r[0]),
        .dout(dout_w[0]), .dvalid(dvalid_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    seq_pattern_tx #(.WIDTH(4), .GAP(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .pattern(pat_r[1][3:0]), .rpt(rpt_r[1]),
        .dout(dout_w[1]), .dvalid(dvalid_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    seq_pattern_tx #(.WIDTH(16), .GAP(15)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_r[2]), .pattern(pat_r[2]), .rpt(rpt_r[2]),
        .dout(dout_w[2]), .dvalid(dvalid_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    // Reference model: copies of the pattern MSB-first, gap cycles between copies,
    // one done cycle, then one idle cycle in which a new start may first be accepted.
    function automatic void model_push(input int w, input int g, input logic [15:0] p,
                                       input int r);
        for (int c = 0; c <= r; c++) begin
            for (int i = 0; i < w; i++) exp_q.push_back({1'b0, 1'b1, 1'b1, p[w-1-i]});
            if (c < r) for (int j = 0; j < g; j++) exp_q.push_back(4'b0100);
        end
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0000);
    endfunction

    // Monitor: every cycle outside reset, the selected instance must match the next record
    // (or be idle when nothing is expected).
    always @(negedge clk) begin
        if (!rst) begin
            mon_act = {done_w[sel], busy_w[sel], dvalid_w[sel], dout_w[sel]};
            mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL cycle_rec inst=%0d t=%0t got={done,busy,dvalid,dout}=%b exp=%b",
                         sel, $time, mon_act, mon_exp);
            end
        end
    end

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Called at negedge+1; start is held across one rising edge and cleared at negedge+1.
    task automatic pulse_start(input int inst, input logic [15:0] p, input logic [3:0] r);
        sel         = inst;
        pat_r[inst] = p;
        rpt_r[inst] = r;
        start_r[inst] = 1'b1;
        if (exp_q.size() == 0) model_push(inst_w[inst], inst_g[inst], p, int'(r));
        @(negedge clk); #1;
        start_r[inst] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq("wait_idle_timeout", n, -1);
            exp_q.delete();
        end
    endtask

    task automatic run_max();
        int n  = 1;
        int dv = 0;
        pulse_start(2, 16'($urandom), 4'd15);
        while (!done_w[2] && n < 600) begin
            if (dvalid_w[2]) dv++;
            @(negedge clk); #1;
            n++;
        end
        check_eq("max_done_seen", int'(done_w[2]), 1);
        check_eq("max_accept_to_done", n - 1, 16 * 16 + 15 * 15);
        check_eq("max_dvalid_cycles", dv, 256);
        wait_idle();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            pat_r[i] = '0;
            rpt_r[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("reset_outputs_inst%0d", i),
                     int'({done_w[i], busy_w[i], dvalid_w[i], dout_w[i]}), 0);
        #1 rst = 1'b0;
        @(negedge clk); #1;

        // Single copy, back-to-back repeats, repeats with gap.
        pulse_start(0, 16'b1101, 4'd0);
        wait_idle();
        pulse_start(0, 16'b1101, 4'd2);
        wait_idle();
        pulse_start(1, 16'b1011, 4'd1);
        wait_idle();

        // Stray start in the 2nd SHIFT cycle, pattern cleared in the 3rd.
        pulse_start(0, 16'b1101, 4'd0);
        @(negedge clk); #1;
        pulse_start(0, 16'b1101, 4'd0);
        pat_r[0] = 16'b0000;
        wait_idle();
        pulse_start(0, 16'b0000, 4'd0);
        wait_idle();

        // Asynchronous reset during the 3rd bit of a rpt=3 transfer.
        pulse_start(0, 16'b0110, 4'd3);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_reset_outputs",
                 int'({done_w[0], busy_w[0], dvalid_w[0], dout_w[0]}), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
        end
        pulse_start(0, 16'b1001, 4'd0);
        wait_idle();

        // Randomized transfers with random stray start pulses.
        for (int t = 0; t < 24; t++) begin
            int inst = $urandom_range(0, 1);
            pulse_start(inst, 16'($urandom), 4'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 12)) begin
                @(negedge clk); #1;
            end
            pulse_start(inst, 16'($urandom), 4'($urandom_range(0, 2)));
            wait_idle();
        end

        run_max();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
